// File: rtl/nano_mem_arbiter.sv
// rtl/nano_mem_arbiter.sv - two-master round-robin arbiter for a single-port 256x16 memory
module nano_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    input  logic [DATA_W-1:0] mem_dataR,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    // beat counts consecutive owned cycles; it never needs to exceed MAX_BURST-1
    localparam logic [3:0] BEAT_MAX = 4'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic       last;
    logic [3:0] beat;
    logic       acc0;
    logic       acc1;

    // Grants are pure decodes of the state register, so req never reaches them combinationally
    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    // An access happens only when the owner is actually requesting
    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;

    // Memory bus follows the owner; without a grant the buses are parked at zero
    always_comb begin
        mem_address = '0;
        mem_dataW   = '0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        if (gnt0) begin
            mem_address = addr0;
            mem_dataW   = wdata0;
            mem_ce      = acc0;
            mem_we      = acc0 & we0;
        end else if (gnt1) begin
            mem_address = addr1;
            mem_dataW   = wdata1;
            mem_ce      = acc1;
            mem_we      = acc1 & we1;
        end
    end

    // Read data is a straight mirror; masters only look at it during their own access
    assign rdata0 = mem_dataR;
    assign rdata1 = mem_dataR;

    // Ownership FSM: round-robin on ties, burst limit only bites when the other side waits
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            beat  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        beat  <= 4'd0;
                    end else if (req1) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        beat  <= 4'd0;
                    end
                end
                OWN0: begin
                    if (req0) begin
                        if (req1 && (beat == BEAT_MAX)) begin
                            state <= OWN1;
                            last  <= 1'b1;
                            beat  <= 4'd0;
                        end else if (beat != BEAT_MAX) begin
                            beat <= beat + 4'd1;
                        end
                    end else begin
                        beat <= 4'd0;
                        if (req1) begin
                            state <= OWN1;
                            last  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                OWN1: begin
                    if (req1) begin
                        if (req0 && (beat == BEAT_MAX)) begin
                            state <= OWN0;
                            last  <= 1'b0;
                            beat  <= 4'd0;
                        end else if (beat != BEAT_MAX) begin
                            beat <= beat + 4'd1;
                        end
                    end else begin
                        beat <= 4'd0;
                        if (req0) begin
                            state <= OWN0;
                            last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= 4'd0;
                end
            endcase
        end
    end

    // Saturating debug counters of completed accesses per master
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0 && (cnt0 != {CNT_W{1'b1}})) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (acc1 && (cnt1 != {CNT_W{1'b1}})) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb/tb_nano_mem_arbiter.sv - self-checking bench for nano_mem_arbiter
module tb_nano_mem_arbiter;

    logic        ck = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  mem_address;
    logic [15:0] mem_dataW, mem_dataR;
    logic        mem_ce, mem_we;
    logic [15:0] cnt0, cnt1;

    nano_mem_arbiter dut (
        .ck(ck), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_dataR(mem_dataR),
        .mem_ce(mem_ce), .mem_we(mem_we), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 ck = ~ck;

    // Memory model: combinational read, write on posedge
    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    assign mem_dataR = mem[mem_address];
    always @(posedge ck) if (mem_we) mem[mem_address] <= mem_dataW;

    typedef struct {
        logic r0; logic w0; logic [7:0] a0; logic [15:0] d0;
        logic r1; logic w1; logic [7:0] a1; logic [15:0] d1;
        logic g0; logic g1; logic ce; logic we; logic [7:0] addr;
    } vec_t;

    typedef struct {
        logic owner; logic [7:0] addr; logic we; logic [15:0] wd; logic [15:0] rd;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt0 = 0;
    logic [15:0] exp_cnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                       input logic g0, input logic g1, input logic ce, input logic we,
                       input logic [7:0] addr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.ce = ce; v.we = we; v.addr = addr;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    initial begin
        sb_t e;
        sb_t got;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0; wdata1 = 16'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 16'h0101) ^ 16'hA5A5;
            shadow[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
        end
        mem[8'h1E]    = 16'h1111;
        shadow[8'h1E] = 16'h1111;

        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 ce we addr
        add(1,0,8'h1E,16'h0,    0,0,8'h00,16'h0,     0,0,0,0,8'h00);  // single read from IDLE
        add(1,0,8'h1E,16'h0,    0,0,8'h00,16'h0,     1,0,1,0,8'h1E);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     1,0,0,0,8'h00);
        add(0,0,8'h00,16'h0,    1,1,8'h0F,16'h5555,  0,0,0,0,8'h00);  // master 1 write/read
        add(0,0,8'h00,16'h0,    1,1,8'h0F,16'h5555,  0,1,1,1,8'h0F);
        add(0,0,8'h00,16'h0,    1,0,8'h0F,16'h0,     0,1,1,0,8'h0F);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     0,1,0,0,8'h00);
        add(1,0,8'h20,16'h0,    1,0,8'h30,16'h0,     0,0,0,0,8'h00);  // fairness, tie to master 0
        for (int k = 0; k < 4; k++) add(1,0,8'h20,16'h0, 1,0,8'h30,16'h0, 1,0,1,0,8'h20);
        for (int k = 0; k < 4; k++) add(1,0,8'h20,16'h0, 1,0,8'h30,16'h0, 0,1,1,0,8'h30);
        for (int k = 0; k < 2; k++) add(1,0,8'h20,16'h0, 1,0,8'h30,16'h0, 1,0,1,0,8'h20);
        add(0,0,8'h00,16'h0,    1,0,8'h30,16'h0,     1,0,0,0,8'h00);  // early release -> master 1
        add(0,0,8'h00,16'h0,    1,0,8'h30,16'h0,     0,1,1,0,8'h30);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     0,1,0,0,8'h00);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     0,0,0,0,8'h00);
        add(1,0,8'h21,16'h0,    0,0,8'h00,16'h0,     0,0,0,0,8'h00);  // master 0 alone, release to IDLE
        add(1,1,8'h21,16'hABCD, 0,0,8'h00,16'h0,     1,0,1,1,8'h21);
        add(1,0,8'h21,16'h0,    0,0,8'h00,16'h0,     1,0,1,0,8'h21);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     1,0,0,0,8'h00);
        add(0,0,8'h00,16'h0,    0,0,8'h00,16'h0,     0,0,0,0,8'h00);

        // Reset held with both requests up
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        rst = 1'b1;
        @(posedge ck); #1;
        chk("first_tie_gnt0", gnt0, 1);
        chk("first_tie_gnt1", gnt1, 0);
        @(negedge ck);
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("own_noreq_ce", mem_ce, 0);

        // Table-driven cycles with a scoreboard of expected accesses
        foreach (tbl[i]) begin
            @(negedge ck);
            drive(tbl[i]);
            if (tbl[i].ce) begin
                e.owner = tbl[i].g1;
                e.addr  = tbl[i].addr;
                e.we    = tbl[i].we;
                e.wd    = tbl[i].g1 ? tbl[i].d1 : tbl[i].d0;
                e.rd    = shadow[tbl[i].addr];
                sb.push_back(e);
            end
            #1;
            chk($sformatf("row%0d_gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("row%0d_gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("row%0d_ce", i), mem_ce, tbl[i].ce);
            chk($sformatf("row%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("row%0d_addr", i), mem_address, tbl[i].addr);
            chk($sformatf("row%0d_excl", i), gnt0 & gnt1, 0);
            chk($sformatf("row%0d_cnt0", i), cnt0, exp_cnt0);
            chk($sformatf("row%0d_cnt1", i), cnt1, exp_cnt1);
            if (mem_ce) begin
                if (sb.size() == 0) begin
                    chk($sformatf("row%0d_sb_empty", i), 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("row%0d_sb_addr", i), mem_address, got.addr);
                    chk($sformatf("row%0d_sb_owner", i), gnt1, got.owner);
                    if (got.we) begin
                        chk($sformatf("row%0d_sb_wdata", i), mem_dataW, got.wd);
                        shadow[got.addr] = got.wd;
                    end else begin
                        chk($sformatf("row%0d_sb_rdata", i), got.owner ? rdata1 : rdata0, got.rd);
                    end
                end
            end
            if (tbl[i].ce && tbl[i].g0) exp_cnt0++;
            if (tbl[i].ce && tbl[i].g1) exp_cnt1++;
        end
        chk("sb_drained", sb.size(), 0);
        @(negedge ck);
        chk("table_cnt0", cnt0, 16'd9);
        chk("table_cnt1", cnt1, 16'd7);

        // Reset asserted in the middle of a master 1 write to 0x10
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hBEEF;
        @(negedge ck);
        chk("midw_gnt1", gnt1, 1);
        chk("midw_we", mem_we, 1);
        #2 rst = 1'b0;
        #1;
        chk("midw_rst_gnt1", gnt1, 0);
        chk("midw_rst_we", mem_we, 0);
        chk("midw_rst_cnt0", cnt0, 0);
        chk("midw_rst_cnt1", cnt1, 0);
        @(posedge ck);
        @(negedge ck);
        chk("midw_mem10", mem[8'h10], shadow[8'h10]);
        req1 = 1'b0; we1 = 1'b0;
        rst = 1'b1;

        // Lone master 0 keeps the grant and its counter saturates
        @(negedge ck);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        repeat (65540) @(posedge ck);
        @(negedge ck);
        chk("sat_gnt0", gnt0, 1);
        chk("sat_cnt0", cnt0, 16'hFFFF);
        chk("sat_cnt1", cnt1, 0);
        req0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
